// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle core: opcodes, stages, instruction classes,
// the sequencer control-strobe bundle and the opcode classifier.
package cpu_pkg;

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned STAGE_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_MOV  = 5'd5,
    OP_MOVI = 5'd6,
    OP_SUBI = 5'd7,
    OP_CMP  = 5'd8,
    OP_B    = 5'd9,
    OP_BLT  = 5'd10,
    OP_BGT  = 5'd11,
    OP_BEQ  = 5'd12,
    OP_J    = 5'd13,
    OP_ST   = 5'd14,
    OP_STI  = 5'd15,
    OP_LD   = 5'd16,
    OP_LDI  = 5'd17,
    OP_NOP  = 5'd30,
    OP_HALT = 5'd31
  } opcode_t;

  typedef enum logic [STAGE_W-1:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } stage_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_CMP, CLS_BR, CLS_JMP, CLS_ST, CLS_LD, CLS_HALT, CLS_NOP
  } instr_class_t;

  // Registered strobes presented to the datapath and memories
  typedef struct packed {
    logic pm_req;
    logic dm_req;
    logic dm_we;
    logic alu_en;
    logic rf_we;
    logic flags_we;
    logic wb_sel_mem;
    logic halted;
  } ctrl_t;

  // Unassigned encodings fall through to NOP
  function automatic instr_class_t classify(input opcode_t op);
    instr_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_MOV, OP_MOVI, OP_SUBI:        cls = CLS_ALU;
      OP_CMP:                          cls = CLS_CMP;
      OP_B, OP_BLT, OP_BGT, OP_BEQ:    cls = CLS_BR;
      OP_J:                            cls = CLS_JMP;
      OP_ST, OP_STI:                   cls = CLS_ST;
      OP_LD, OP_LDI:                   cls = CLS_LD;
      OP_HALT:                         cls = CLS_HALT;
      default:                         cls = CLS_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/branch_unit.sv
// Branch condition evaluation and next-pc computation.
// op/tgt come from the instruction register; pc is the already-incremented pc.
// next_pc_c: relative target (pc + sext(tgt)) for taken branches, zext(tgt) for J,
// otherwise pc unchanged.
module branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 6,
  parameter int unsigned TGT_W = 6
) (
  input  opcode_t          op,
  input  logic [TGT_W-1:0] tgt,
  input  logic [PC_W-1:0]  pc,
  input  logic             flag_lt,
  input  logic             flag_gt,
  input  logic             flag_eq,
  output logic [PC_W-1:0]  next_pc_c
);

  logic taken_c;

  always_comb begin
    taken_c   = 1'b0;
    next_pc_c = pc;
    case (op)
      OP_B:    taken_c = 1'b1;
      OP_BLT:  taken_c = flag_lt;
      OP_BGT:  taken_c = flag_gt;
      OP_BEQ:  taken_c = flag_eq;
      OP_J:    taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
    if (taken_c) begin
      if (op == OP_J) next_pc_c = PC_W'(tgt);
      else            next_pc_c = pc + PC_W'($signed(tgt));
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: owns pc/ir and steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB with ready-handshaked program/data memory and
// halt/single-step debug.
// Ports: clock/reset (async active-low); pm_req/pm_ready/pm_rdata program fetch;
// dm_req/dm_we/dm_ready data access; flag_lt/gt/eq compare flags; ir, pc, stage
// trace; alu_en/rf_we/flags_we/wb_sel_mem datapath strobes; halt_req/step/halted debug.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_W    = 6,
  parameter int unsigned TGT_W   = 6
) (
  input  logic               clock,
  input  logic               reset,
  output logic               pm_req,
  input  logic               pm_ready,
  input  logic [INSTR_W-1:0] pm_rdata,
  output logic               dm_req,
  output logic               dm_we,
  input  logic               dm_ready,
  input  logic               flag_lt,
  input  logic               flag_gt,
  input  logic               flag_eq,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    pc,
  output logic               alu_en,
  output logic               rf_we,
  output logic               flags_we,
  output logic               wb_sel_mem,
  output logic [2:0]         stage,
  input  logic               halt_req,
  input  logic               step,
  output logic               halted
);

  stage_t             stage_q, stage_d, boundary_c;
  logic [PC_W-1:0]    pc_q, pc_d, br_next_pc;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               single_q, single_d;
  ctrl_t              ctrl_q, ctrl_d;
  opcode_t            op_c;
  instr_class_t       cls_c, nxt_cls;

  assign op_c  = opcode_t'(ir_q[INSTR_W-1 -: OPC_W]);
  assign cls_c = classify(op_c);

  branch_unit #(
    .PC_W  (PC_W),
    .TGT_W (TGT_W)
  ) u_branch (
    .op        (op_c),
    .tgt       (ir_q[TGT_W-1:0]),
    .pc        (pc_q),
    .flag_lt   (flag_lt),
    .flag_gt   (flag_gt),
    .flag_eq   (flag_eq),
    .next_pc_c (br_next_pc)
  );

  // State register; FETCH is the reset stage so the fetch request is live out of reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q       <= FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      single_q      <= 1'b0;
      ctrl_q        <= '0;
      ctrl_q.pm_req <= 1'b1;
    end else begin
      stage_q  <= stage_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      single_q <= single_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Next-state and next-strobe logic; strobes are decoded from the next stage
  always_comb begin
    stage_d  = stage_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    single_d = single_q;
    ctrl_d   = '0;
    nxt_cls  = CLS_NOP;

    // Instruction boundary: a pending halt or an in-flight single step parks the core
    boundary_c = (halt_req || single_q) ? HALTED : FETCH;

    case (stage_q)
      FETCH: begin
        if (pm_ready) begin
          ir_d    = pm_rdata;
          pc_d    = pc_q + PC_W'(1);
          stage_d = DECODE;
        end
      end
      DECODE: begin
        case (cls_c)
          CLS_HALT: stage_d = HALTED;
          CLS_NOP:  stage_d = boundary_c;
          default:  stage_d = EXEC;
        endcase
      end
      EXEC: begin
        case (cls_c)
          CLS_ALU:         stage_d = WB;
          CLS_ST, CLS_LD:  stage_d = MEM;
          CLS_BR, CLS_JMP: begin
            pc_d    = br_next_pc;
            stage_d = boundary_c;
          end
          default:         stage_d = boundary_c;
        endcase
      end
      MEM: begin
        if (dm_ready) stage_d = (cls_c == CLS_LD) ? WB : boundary_c;
      end
      WB: stage_d = boundary_c;
      HALTED: begin
        if (step) begin
          stage_d  = FETCH;
          single_d = 1'b1;
        end else if (!halt_req) begin
          stage_d  = FETCH;
        end
      end
      default: stage_d = FETCH;
    endcase

    if (stage_d == HALTED) single_d = 1'b0;

    nxt_cls           = classify(opcode_t'(ir_d[INSTR_W-1 -: OPC_W]));
    ctrl_d.pm_req     = (stage_d == FETCH);
    ctrl_d.dm_req     = (stage_d == MEM);
    ctrl_d.dm_we      = (stage_d == MEM) && (nxt_cls == CLS_ST);
    ctrl_d.alu_en     = (stage_d == EXEC);
    ctrl_d.rf_we      = (stage_d == WB);
    ctrl_d.flags_we   = (stage_d == EXEC) && (nxt_cls == CLS_CMP);
    ctrl_d.wb_sel_mem = (stage_d == WB) && (nxt_cls == CLS_LD);
    ctrl_d.halted     = (stage_d == HALTED);
  end

  assign pm_req     = ctrl_q.pm_req;
  assign dm_req     = ctrl_q.dm_req;
  assign dm_we      = ctrl_q.dm_we;
  assign alu_en     = ctrl_q.alu_en;
  assign rf_we      = ctrl_q.rf_we;
  assign flags_we   = ctrl_q.flags_we;
  assign wb_sel_mem = ctrl_q.wb_sel_mem;
  assign halted     = ctrl_q.halted;
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign stage      = stage_q;

endmodule
